// File: rtl/div_result_collector.sv
// Result collector behind the pipelined divider: FWFT result FIFO, in-flight tracking and START credit.
// Define DIV_RESULT_TAG_EN to add an 8-bit issue tag (OUT_TAG) that travels with each result.
module div_result_collector #(
  parameter int TAMANYO = 4,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 16
) (
  input  logic                         CLK,
  input  logic                         RSTa,
  input  logic                         START_IN,
  input  logic                         FIN,
  input  logic [TAMANYO-1:0]           COC_IN,
  input  logic [TAMANYO-1:0]           RES_IN,
  input  logic                         OUT_READY,
  output logic                         OUT_VALID,
  output logic [TAMANYO-1:0]           OUT_COC,
  output logic [TAMANYO-1:0]           OUT_RES,
  output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
  output logic                         ISSUE_OK,
  output logic                         OVERFLOW,
  output logic                         UNDERFLOW
`ifdef DIV_RESULT_TAG_EN
  ,
  output logic [7:0]                   OUT_TAG
`endif
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [IW-1:0] INFL_MAX   = '1;
  localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);

  logic [TAMANYO-1:0] coc_mem [DEPTH];
  logic [TAMANYO-1:0] res_mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [LW-1:0]      level;
  logic [IW-1:0]      infl;
  logic               overflow;
  logic               underflow;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic               credit;

  always_comb begin
    full   = (level == FULL_LEVEL);
    pop    = (level != '0) && OUT_READY;
    push   = FIN && (!full || pop);
    drop   = FIN && full && !pop;
    credit = (int'(infl) + int'(level)) < DEPTH;
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      for (int i = 0; i < DEPTH; i++) begin
        coc_mem[i] <= '0;
        res_mem[i] <= '0;
      end
    end else if (push) begin
      coc_mem[wr_ptr] <= COC_IN;
      res_mem[wr_ptr] <= RES_IN;
    end
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A FIN with nothing in flight leaves the counter at zero rather than wrapping.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      infl <= '0;
    end else begin
      case ({START_IN, FIN})
        2'b10: if (infl != INFL_MAX) infl <= infl + IW'(1);
        2'b01: if (infl != '0) infl <= infl - IW'(1);
        default: infl <= infl;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop || (START_IN && !credit)) begin
        overflow <= 1'b1;
      end
      if (FIN && (infl == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

  assign OUT_VALID = (level != '0);
  assign OUT_COC   = coc_mem[rd_ptr];
  assign OUT_RES   = res_mem[rd_ptr];
  assign LEVEL     = level;
  assign ISSUE_OK  = credit;
  assign OVERFLOW  = overflow;
  assign UNDERFLOW = underflow;

`ifdef DIV_RESULT_TAG_EN
  logic [7:0] issue_cnt;
  logic [7:0] tag_line [LATENCY];
  logic [7:0] tag_mem  [DEPTH];

  // Stage 0 samples the counter every cycle; the value reaching the end lines up with FIN.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      issue_cnt <= 8'd0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_line[i] <= 8'd0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem[i] <= 8'd0;
      end
    end else begin
      if (START_IN) begin
        issue_cnt <= issue_cnt + 8'd1;
      end
      tag_line[0] <= issue_cnt;
      for (int i = 1; i < LATENCY; i++) begin
        tag_line[i] <= tag_line[i-1];
      end
      if (push) begin
        tag_mem[wr_ptr] <= tag_line[LATENCY-1];
      end
    end
  end

  assign OUT_TAG = (level != '0) ? tag_mem[rd_ptr] : 8'd0;
`endif

endmodule

// File: tb/tb_div_result_collector.sv
// Scoreboard bench for div_result_collector: a divider latency model feeds FIN,
// expected results are queued at START and compared on every output handshake.
module tb_div_result_collector;

  localparam int TAMANYO = 4;
  localparam int DEPTH   = 4;
  localparam int LAT     = 16;

  typedef struct packed {
    logic [7:0] tag;
    logic [3:0] coc;
    logic [3:0] res;
  } exp_t;

  logic       CLK;
  logic       RSTa;
  logic       START_IN;
  logic       FIN;
  logic [3:0] COC_IN;
  logic [3:0] RES_IN;
  logic       OUT_READY;
  logic       OUT_VALID;
  logic [3:0] OUT_COC;
  logic [3:0] OUT_RES;
  logic [2:0] LEVEL;
  logic       ISSUE_OK;
  logic       OVERFLOW;
  logic       UNDERFLOW;
`ifdef DIV_RESULT_TAG_EN
  logic [7:0] OUT_TAG;
`endif

  logic       pipe_v [LAT];
  logic [3:0] pipe_c [LAT];
  logic [3:0] pipe_r [LAT];
  logic [3:0] start_c, start_r;
  logic       fin_force;
  logic [3:0] force_c, force_r;
  logic [7:0] tag_cnt;
  logic       tag_chk;
  exp_t       sb [$];
  int         check_count;
  int         pass_count;
  int         pop_count;

  div_result_collector #(.TAMANYO(TAMANYO), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RSTa(RSTa), .START_IN(START_IN), .FIN(FIN),
    .COC_IN(COC_IN), .RES_IN(RES_IN), .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID), .OUT_COC(OUT_COC), .OUT_RES(OUT_RES),
    .LEVEL(LEVEL), .ISSUE_OK(ISSUE_OK), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
`ifdef DIV_RESULT_TAG_EN
    , .OUT_TAG(OUT_TAG)
`endif
  );

  assign FIN    = pipe_v[LAT-1] | fin_force;
  assign COC_IN = fin_force ? force_c : pipe_c[LAT-1];
  assign RES_IN = fin_force ? force_r : pipe_r[LAT-1];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, obs, exp, $time);
  endtask

  task automatic clearModel();
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_c[i] = 4'd0;
      pipe_r[i] = 4'd0;
    end
    sb.delete();
    tag_cnt   = 8'd0;
    START_IN  = 1'b0;
    fin_force = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [3:0] r);
    START_IN = 1'b1;
    start_c  = c;
    start_r  = r;
    sb.push_back('{tag: tag_cnt, coc: c, res: r});
    tag_cnt  = tag_cnt + 8'd1;
  endtask

  task automatic forceFin(input logic [3:0] c, input logic [3:0] r);
    fin_force = 1'b1;
    force_c   = c;
    force_r   = r;
    sb.push_back('{tag: 8'd0, coc: c, res: r});
  endtask

  // Pops are scored just before the edge that performs them; the divider model shifts after it.
  task automatic tick();
    exp_t e;
    if (OUT_VALID && OUT_READY) begin
      checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("out_coc", 32'(OUT_COC), 32'(e.coc));
        checkOutput("out_res", 32'(OUT_RES), 32'(e.res));
`ifdef DIV_RESULT_TAG_EN
        if (tag_chk) checkOutput("out_tag", 32'(OUT_TAG), 32'(e.tag));
`endif
        pop_count++;
      end
    end
    @(posedge CLK);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_c[i] = pipe_c[i-1];
      pipe_r[i] = pipe_r[i-1];
    end
    pipe_v[0] = START_IN;
    pipe_c[0] = start_c;
    pipe_r[0] = start_r;
    START_IN  = 1'b0;
    fin_force = 1'b0;
  endtask

  task automatic doReset();
    RSTa = 1'b0;
    clearModel();
    OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTa = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic waitLevel(input int lvl, input int budget);
    int n = 0;
    while (int'(LEVEL) != lvl && n < budget) begin
      tick();
      n++;
    end
    checkOutput("wait_level", 32'(LEVEL), 32'(lvl));
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    OUT_READY = 1'b1;
    while ((OUT_VALID || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_sb", 32'(sb.size()), 32'd0);
    OUT_READY = 1'b0;
  endtask

  initial begin
    int start_pops;
    int issued;
    int n;
    check_count = 0;
    pass_count  = 0;
    pop_count   = 0;
    tag_chk     = 1'b0;
    start_c     = 4'd0;
    start_r     = 4'd0;
    force_c     = 4'd0;
    force_r     = 4'd0;
    OUT_READY   = 1'b0;
    RSTa        = 1'b0;
    clearModel();
    #1;
    checkOutput("rst_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_level", 32'(LEVEL), 32'd0);
    checkOutput("rst_issue_ok", 32'(ISSUE_OK), 32'd1);
    checkOutput("rst_overflow", 32'(OVERFLOW), 32'd0);
    checkOutput("rst_underflow", 32'(UNDERFLOW), 32'd0);
    checkOutput("rst_coc", 32'(OUT_COC), 32'd0);
    checkOutput("rst_res", 32'(OUT_RES), 32'd0);
    doReset();

    $display("[TB] single operation");
    applyStimulus(4'd3, 4'd1);
    for (int i = 0; i < LAT; i++) begin
      tick();
      checkOutput("single_issue_ok", 32'(ISSUE_OK), 32'd1);
    end
    checkOutput("single_not_yet", 32'(OUT_VALID), 32'd0);
    tick();
    checkOutput("single_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("single_coc", 32'(OUT_COC), 32'd3);
    checkOutput("single_res", 32'(OUT_RES), 32'd1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    checkOutput("single_level", 32'(LEVEL), 32'd0);
    checkOutput("single_empty", 32'(OUT_VALID), 32'd0);

    $display("[TB] credit exhaustion");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'(4 + i), 4'(i));
      tick();
      if (i == 2) checkOutput("credit_3rd", 32'(ISSUE_OK), 32'd1);
    end
    checkOutput("credit_4th", 32'(ISSUE_OK), 32'd0);
    waitLevel(4, 40);
    checkOutput("credit_full", 32'(ISSUE_OK), 32'd0);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    checkOutput("credit_pop_level", 32'(LEVEL), 32'd3);
    checkOutput("credit_pop_ok", 32'(ISSUE_OK), 32'd1);

    $display("[TB] full FIFO push with pop");
    applyStimulus(4'd9, 4'd2);
    tick();
    waitLevel(4, 40);
    forceFin(4'd10, 4'd5);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    checkOutput("full_pp_level", 32'(LEVEL), 32'd4);
    checkOutput("full_pp_overflow", 32'(OVERFLOW), 32'd0);
    checkOutput("fin_no_flight_underflow", 32'(UNDERFLOW), 32'd1);
    waitDrain(20);

    $display("[TB] credit violation");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'(11 + i), 4'(i));
      tick();
    end
    checkOutput("viol_pre_ok", 32'(ISSUE_OK), 32'd0);
    checkOutput("viol_pre_ovf", 32'(OVERFLOW), 32'd0);
    applyStimulus(4'd15, 4'd0);
    tick();
    checkOutput("viol_overflow", 32'(OVERFLOW), 32'd1);
    waitDrain(60);
    checkOutput("viol_sticky", 32'(OVERFLOW), 32'd1);
    checkOutput("viol_credit_back", 32'(ISSUE_OK), 32'd1);

    $display("[TB] wrap-around stream");
    doReset();
    checkOutput("clr_overflow", 32'(OVERFLOW), 32'd0);
    checkOutput("clr_underflow", 32'(UNDERFLOW), 32'd0);
    tag_chk    = 1'b1;
    start_pops = pop_count;
    issued     = 0;
    n          = 0;
    while (pop_count - start_pops < 10 && n < 600) begin
      OUT_READY = 1'($urandom_range(0, 1));
      if (issued < 10 && ISSUE_OK) begin
        applyStimulus(4'(issued), 4'(9 - issued));
        issued++;
      end
      tick();
      n++;
    end
    OUT_READY = 1'b0;
    tag_chk   = 1'b0;
    checkOutput("wrap_pops", 32'(pop_count - start_pops), 32'd10);
    checkOutput("wrap_overflow", 32'(OVERFLOW), 32'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'(i), 4'(i));
      tick();
    end
    repeat (13) tick();
    checkOutput("mid_level", 32'(LEVEL), 32'd2);
    checkOutput("mid_overflow", 32'(OVERFLOW), 32'd1);
    #2;
    RSTa = 1'b0;
    #1;
    checkOutput("mid_rst_level", 32'(LEVEL), 32'd0);
    checkOutput("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("mid_rst_issue_ok", 32'(ISSUE_OK), 32'd1);
    checkOutput("mid_rst_overflow", 32'(OVERFLOW), 32'd0);
    checkOutput("mid_rst_underflow", 32'(UNDERFLOW), 32'd0);
    doReset();
    checkOutput("post_rst_issue_ok", 32'(ISSUE_OK), 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
